// File: rtl/draw_background_scroll_if.sv
// Raster timing bundle: counters plus sync/blank strobes.
// The producer drives it through master; the consumer reads it through slave.
interface draw_background_scroll_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        vblnk;
    logic        hsync;
    logic        hblnk;

    modport master (output vcount, hcount, vsync, vblnk, hsync, hblnk);
    modport slave  (input  vcount, hcount, vsync, vblnk, hsync, hblnk);
endinterface

// File: rtl/draw_background_scroll.sv
// Vertically scrolling tiled background.
// Texture address is built from scrolled vcount/hcount; colour is returned ROM_LATENCY+2 cycles later.
module draw_background_scroll #(
    parameter int unsigned      TILE_LOG2   = 2,
    parameter int unsigned      MAP_W_LOG2  = 4,
    parameter int unsigned      MAP_H_LOG2  = 4,
    parameter int unsigned      ROM_LATENCY = 1,
    parameter int unsigned      RGB_W       = 12,
    parameter logic [RGB_W-1:0] BLANK_RGB   = '0
) (
    input  logic                             pclk_in,
    input  logic                             rst_in,
    draw_background_scroll_if.slave          tim_in,
    draw_background_scroll_if.master         tim_out,
    input  logic [10:0]                      scroll_in,
    input  logic                             enable_in,
    output logic [MAP_H_LOG2+MAP_W_LOG2-1:0] pixel_addr,
    input  logic [RGB_W-1:0]                 rgb_pixel,
    output logic [RGB_W-1:0]                 rgb_out,
    output logic                             frame_tick
);

    localparam int unsigned L = ROM_LATENCY + 2;

    typedef struct packed {
        logic [10:0] vcount;
        logic [10:0] hcount;
        logic        vsync;
        logic        vblnk;
        logic        hsync;
        logic        hblnk;
        logic        blank;
        logic        en;
    } tim_t;

    tim_t                            tim_d;
    tim_t                            tim_q [L];
    logic [10:0]                     y;
    logic [MAP_H_LOG2+MAP_W_LOG2-1:0] addr_d, addr_q;
    logic [10:0]                     scroll_act_q;
    logic                            vblnk_prev_q;
    logic                            armed_q;
    logic                            load;
    logic                            frame_tick_q;
    logic [RGB_W-1:0]                rgb_d, rgb_q;
    logic                            unused_bits;

    always_comb begin
        tim_d.vcount = tim_in.vcount;
        tim_d.hcount = tim_in.hcount;
        tim_d.vsync  = tim_in.vsync;
        tim_d.vblnk  = tim_in.vblnk;
        tim_d.hsync  = tim_in.hsync;
        tim_d.hblnk  = tim_in.hblnk;
        tim_d.blank  = tim_in.vblnk | tim_in.hblnk;
        tim_d.en     = enable_in;
    end

    // 11-bit wrap is intentional; the texture then wraps by truncation.
    assign y      = tim_in.vcount + scroll_act_q;
    assign addr_d = {y[TILE_LOG2 +: MAP_H_LOG2], tim_in.hcount[TILE_LOG2 +: MAP_W_LOG2]};

    // armed_q keeps a vblnk already high at reset release from counting as a rising edge.
    assign load = armed_q & tim_in.vblnk & ~vblnk_prev_q;

    // Blank/enable for this pixel sit one stage ahead of the timing output, matching ROM data.
    assign rgb_d = (tim_q[L-2].blank | ~tim_q[L-2].en) ? BLANK_RGB : rgb_pixel;

    always_ff @(posedge pclk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < L; i++) begin
                tim_q[i] <= '0;
            end
            addr_q       <= '0;
            scroll_act_q <= '0;
            vblnk_prev_q <= 1'b0;
            armed_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            rgb_q        <= BLANK_RGB;
        end else begin
            tim_q[0] <= tim_d;
            for (int unsigned i = 1; i < L; i++) begin
                tim_q[i] <= tim_q[i-1];
            end
            addr_q       <= addr_d;
            vblnk_prev_q <= tim_in.vblnk;
            armed_q      <= 1'b1;
            frame_tick_q <= load;
            if (load) begin
                scroll_act_q <= scroll_in;
            end
            rgb_q <= rgb_d;
        end
    end

    assign tim_out.vcount = tim_q[L-1].vcount;
    assign tim_out.hcount = tim_q[L-1].hcount;
    assign tim_out.vsync  = tim_q[L-1].vsync;
    assign tim_out.vblnk  = tim_q[L-1].vblnk;
    assign tim_out.hsync  = tim_q[L-1].hsync;
    assign tim_out.hblnk  = tim_q[L-1].hblnk;

    assign pixel_addr = addr_q;
    assign rgb_out    = rgb_q;
    assign frame_tick = frame_tick_q;

    // Only a window of y/hcount selects the texel; the last stage's blank/en are not needed.
    assign unused_bits = ^{y, tim_in.hcount, tim_q[L-1].blank, tim_q[L-1].en};

endmodule
